// File: rtl/fetch_seq_pkg.sv
// Shared types and Power ISA branch encodings for the fetch sequencer.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        ISSUE,
        HALT,
        FAULT
    } state_t;

    localparam logic [5:0] OPC_B     = 6'd18;
    localparam logic [5:0] OPC_BC    = 6'd16;
    localparam logic [5:0] OPC_XL    = 6'd19;
    localparam logic [9:0] XO_BCLR   = 10'd16;
    localparam logic [9:0] XO_BCCTR  = 10'd528;
    localparam logic [9:0] XO_BCTAR  = 10'd560;

    typedef struct packed {
        logic i_form;
        logic b_form;
        logic cond_lr;
        logic cond_ctr;
        logic cond_tar;
    } branch_form_t;

    function automatic logic form_any(input branch_form_t f);
        return f.i_form | f.b_form | f.cond_lr | f.cond_ctr | f.cond_tar;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/response channel between sequencer and imem.
interface fetch_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [0:63] req_addr;
    logic        rsp_valid;
    logic [0:31] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/branch_form_decode.sv
// Classifies an instruction (bit 0 = MSB) into one of the branch forms, or none.
module branch_form_decode
    import fetch_seq_pkg::*;
(
    input  logic [0:31]  instr,
    output branch_form_t form
);

    logic [5:0] opcode;
    logic [9:0] xo;
    logic       unused_bits;

    assign opcode      = instr[0:5];
    assign xo          = instr[21:30];
    assign unused_bits = ^{instr[6:20], instr[31]};

    always_comb begin
        form          = '0;
        form.i_form   = (opcode == OPC_B);
        form.b_form   = (opcode == OPC_BC);
        form.cond_lr  = (opcode == OPC_XL) && (xo == XO_BCLR);
        form.cond_ctr = (opcode == OPC_XL) && (xo == XO_BCCTR);
        form.cond_tar = (opcode == OPC_XL) && (xo == XO_BCTAR);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches one instruction at a time and grants the BranchFacility exactly one
// unstalled cycle per instruction; owns stall, halt and fault policy.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [0:63] RESET_ADDR = 64'h0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    fetch_sequencer_if.master        imem,
    input  logic [0:63]              i_nia,
    output logic                     o_stall,
    output logic                     o_en,
    output logic [0:31]              o_instr,
    output logic                     o_i_form,
    output logic                     o_b_form,
    output logic                     o_cond_LR,
    output logic                     o_cond_CTR,
    output logic                     o_cond_TAR,
    input  logic                     i_halt,
    output logic                     o_halted,
    output logic [0:63]              o_retired,
    output logic                     o_fault,
    output logic                     o_err_protocol
);

    state_t       state_q, state_d;
    logic [0:63]  fetch_addr_q, fetch_addr_d;
    logic [0:31]  instr_q, instr_d;
    logic [0:63]  retired_q, retired_d;
    logic [7:0]   tmo_cnt_q, tmo_cnt_d;
    logic [7:0]   tmo_inc;
    logic         err_protocol_q, err_protocol_d;
    branch_form_t form;

    assign tmo_inc = tmo_cnt_q + 8'd1;

    branch_form_decode u_decode (
        .instr (instr_q),
        .form  (form)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = i_halt ? HALT : REQ;
            REQ:     if (imem.req_ready) state_d = WAIT;
            WAIT: begin
                if (imem.rsp_valid) begin
                    state_d = imem.rsp_err ? FAULT : ISSUE;
                end else if (tmo_inc == 8'(TIMEOUT)) begin
                    state_d = FAULT;
                end
            end
            ISSUE:   state_d = i_halt ? HALT : REQ;
            HALT:    if (!i_halt) state_d = REQ;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_addr_d   = fetch_addr_q;
        instr_d        = instr_q;
        retired_d      = retired_q;
        tmo_cnt_d      = tmo_cnt_q;
        // Responses are only legal in WAIT; one landing in BOOT is a leftover
        // from before reset and is silently dropped.
        err_protocol_d = err_protocol_q |
                         (imem.rsp_valid && (state_q != WAIT) && (state_q != BOOT));
        unique case (state_q)
            REQ: begin
                if (imem.req_ready) tmo_cnt_d = 8'd0;
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    if (!imem.rsp_err) instr_d = imem.rsp_data;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            ISSUE: begin
                fetch_addr_d = i_nia;
                retired_d    = retired_q + 64'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_addr_q   <= RESET_ADDR;
            instr_q        <= '0;
            retired_q      <= '0;
            tmo_cnt_q      <= '0;
            err_protocol_q <= 1'b0;
        end else begin
            fetch_addr_q   <= fetch_addr_d;
            instr_q        <= instr_d;
            retired_q      <= retired_d;
            tmo_cnt_q      <= tmo_cnt_d;
            err_protocol_q <= err_protocol_d;
        end
    end

    always_comb begin
        imem.req_valid = (state_q == REQ);
        imem.req_addr  = fetch_addr_q;
        o_stall        = (state_q != ISSUE);
        o_instr        = instr_q;
        o_i_form       = 1'b0;
        o_b_form       = 1'b0;
        o_cond_LR      = 1'b0;
        o_cond_CTR     = 1'b0;
        o_cond_TAR     = 1'b0;
        o_en           = 1'b0;
        if (state_q == ISSUE) begin
            o_i_form   = form.i_form;
            o_b_form   = form.b_form;
            o_cond_LR  = form.cond_lr;
            o_cond_CTR = form.cond_ctr;
            o_cond_TAR = form.cond_tar;
            o_en       = form_any(form);
        end
        o_halted       = (state_q == HALT);
        o_fault        = (state_q == FAULT);
        o_err_protocol = err_protocol_q;
        o_retired      = retired_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: small imem responder plus a stand-in for the BranchFacility nia.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [0:63] nia;
    logic        stall, en;
    logic [0:31] instr;
    logic        i_form, b_form, cond_lr, cond_ctr, cond_tar;
    logic        halt;
    logic        halted;
    logic [0:63] retired;
    logic        fault;
    logic        err_protocol;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_ADDR (64'h0),
        .TIMEOUT    (255)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .imem           (bus),
        .i_nia          (nia),
        .o_stall        (stall),
        .o_en           (en),
        .o_instr        (instr),
        .o_i_form       (i_form),
        .o_b_form       (b_form),
        .o_cond_LR      (cond_lr),
        .o_cond_CTR     (cond_ctr),
        .o_cond_TAR     (cond_tar),
        .i_halt         (halt),
        .o_halted       (halted),
        .o_retired      (retired),
        .o_fault        (fault),
        .o_err_protocol (err_protocol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        auto_rsp = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic [63:0] ofs      = 64'd4;
    logic        use_lr   = 1'b0;
    logic [63:0] lr_val   = 64'h0;
    logic        hs_q;
    logic [63:0] hs_addr;

    // Remember the last accepted request so the responder and nia model can follow it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q    <= 1'b0;
            hs_addr <= 64'h0;
        end else begin
            hs_q <= bus.req_valid & bus.req_ready;
            if (bus.req_valid & bus.req_ready) hs_addr <= bus.req_addr;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (auto_rsp) begin
                bus.rsp_valid = hs_q;
                bus.rsp_data  = mem_data;
                bus.rsp_err   = 1'b0;
            end
            nia = use_lr ? (lr_val & ~64'h3) : (hs_addr + ofs);
        end
    endtask

    // Leaves the DUT in REQ, one cycle after BOOT.
    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic run_one(input string tag, input logic [31:0] data, input logic [63:0] addr,
                           input logic [4:0] exp_form, input logic [63:0] exp_next);
        mem_data = data;
        check({tag, " req_valid"}, 64'(bus.req_valid), 64'd1);
        check({tag, " req_addr"}, bus.req_addr, addr);
        step(2);
        check({tag, " stall"}, 64'(stall), 64'd0);
        check({tag, " en"}, 64'(en), 64'(|exp_form));
        check({tag, " forms"}, 64'({i_form, b_form, cond_lr, cond_ctr, cond_tar}),
              64'(exp_form));
        check({tag, " instr"}, 64'(instr), 64'(data));
        step(1);
        check({tag, " next_addr"}, bus.req_addr, exp_next);
    endtask

    initial begin
        rst           = 1'b1;
        halt          = 1'b0;
        nia           = '0;
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_err   = 1'b0;

        step(2);
        check("rst stall", 64'(stall), 64'd1);
        check("rst outputs", 64'({en, bus.req_valid, halted, fault, err_protocol}), 64'd0);
        check("rst retired", retired, 64'd0);
        rst = 1'b0;
        check("boot req_valid", 64'(bus.req_valid), 64'd0);
        check("boot stall", 64'(stall), 64'd1);
        auto_rsp = 1'b1;
        step(1);

        // Three nops with zero-wait memory.
        mem_data = 32'h6000_0000;
        run_one("nop0", 32'h6000_0000, 64'h0, 5'b00000, 64'h4);
        run_one("nop1", 32'h6000_0000, 64'h4, 5'b00000, 64'h8);
        run_one("nop2", 32'h6000_0000, 64'h8, 5'b00000, 64'hC);
        check("retired after nops", retired, 64'd3);

        // Branch forms, starting from a fresh reset.
        do_reset();
        ofs = 64'd16;
        run_one("b", 32'h4800_0010, 64'h0, 5'b10000, 64'h10);
        ofs = 64'd4;
        run_one("bc", 32'h4082_0008, 64'h10, 5'b01000, 64'h14);
        run_one("bcctr", 32'h4E80_0420, 64'h14, 5'b00010, 64'h18);
        run_one("bctar", 32'h4E80_0460, 64'h18, 5'b00001, 64'h1C);
        run_one("mcrf", 32'h4C00_0000, 64'h1C, 5'b00000, 64'h20);
        use_lr = 1'b1;
        lr_val = 64'h1237;
        run_one("bclr", 32'h4E80_0020, 64'h20, 5'b00100, 64'h1234);
        use_lr = 1'b0;
        check("retired after branches", retired, 64'd6);

        // Back-pressure holds the request stable.
        bus.req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall req_valid", 64'(bus.req_valid), 64'd1);
            check("stall req_addr", bus.req_addr, 64'h1234);
        end

        // No response ever comes back: timeout after 255 WAIT cycles.
        auto_rsp      = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b1;
        step(1);
        bus.req_ready = 1'b0;
        step(254);
        check("timeout early fault", 64'(fault), 64'd0);
        check("timeout wait stall", 64'(stall), 64'd1);
        step(1);
        check("timeout fault", 64'(fault), 64'd1);
        bus.req_ready = 1'b1;
        step(4);
        check("fault no req", 64'(bus.req_valid), 64'd0);
        check("fault sticky", 64'(fault), 64'd1);

        // Halt requested while the fetch is in flight.
        auto_rsp = 1'b1;
        mem_data = 32'h6000_0000;
        do_reset();
        check("halt start addr", bus.req_addr, 64'h0);
        step(1);
        halt = 1'b1;
        step(1);
        check("halt issue stall", 64'(stall), 64'd0);
        check("halt issue halted", 64'(halted), 64'd0);
        step(1);
        check("halted", 64'(halted), 64'd1);
        check("halted stall", 64'(stall), 64'd1);
        check("halted no req", 64'(bus.req_valid), 64'd0);
        step(2);
        check("halted held", 64'(halted), 64'd1);
        check("halted retired", retired, 64'd1);
        halt = 1'b0;
        step(1);
        check("resume halted", 64'(halted), 64'd0);
        check("resume req_valid", 64'(bus.req_valid), 64'd1);
        check("resume addr", bus.req_addr, 64'h4);

        // Stray response in REQ, then an error response in WAIT.
        auto_rsp      = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b0;
        do_reset();
        check("proto clear", 64'(err_protocol), 64'd0);
        bus.rsp_valid = 1'b1;
        step(1);
        bus.rsp_valid = 1'b0;
        check("proto set", 64'(err_protocol), 64'd1);
        check("proto no fault", 64'(fault), 64'd0);
        bus.req_ready = 1'b1;
        step(1);
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
        step(1);
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        check("rsp_err fault", 64'(fault), 64'd1);
        step(3);
        check("sticky both", 64'({fault, err_protocol}), 64'b11);
        check("fault no req 2", 64'(bus.req_valid), 64'd0);
        rst = 1'b1;
        step(1);
        check("reset clears", 64'({fault, err_protocol}), 64'b00);
        rst = 1'b0;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
